pam4_sym_src: RTL and testbench

- Transmit-side source stage: PAM-4 symbol generator and sample/symbol clock-enable generator.
- Produces the sample-rate and symbol-rate enables (4 samples per symbol) consumed by the SRRC transmit filters.
- Produces an 18-bit signed PAM-4 symbol stream, one symbol per symbol period, taken from a PRBS, an impulse, or a Nyquist-tone pattern.
- Sits directly upstream of the SRRC transmit filter. Its symbol output is held stable across the filter's symbol-capture edge.

---
 rtl/pam4_sym_src_pkg.sv | 39 +++
 rtl/pam4_sym_src_if.sv | 21 ++
 rtl/pam4_sym_src_prbs22_lfsr.sv | 49 ++++
 rtl/pam4_sym_src.sv | 144 ++++++++++++++
 tb/tb_pam4_sym_src.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pam4_sym_src_pkg.sv
// ============================================================================
// Module      : pam4_sym_src_pkg
// Description : Shared PAM-4 symbol levels, mode encodings and Gray mapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pam4_sym_src_pkg;

    localparam int LFSR_W = 22;
    localparam int SYM_W  = 18;

    // 1s17 fixed-point symbol levels
    localparam logic [SYM_W-1:0] SYMBOL_P2 = 18'h18000;
    localparam logic [SYM_W-1:0] SYMBOL_P1 = 18'h08000;
    localparam logic [SYM_W-1:0] SYMBOL_N1 = 18'h38000;
    localparam logic [SYM_W-1:0] SYMBOL_N2 = 18'h28000;

    typedef enum logic [1:0] {
        MODE_PRBS = 2'd0,
        MODE_IMP  = 2'd1,
        MODE_TONE = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    function automatic logic [SYM_W-1:0] gray_map(input logic [1:0] b);
        logic [SYM_W-1:0] lvl;
        case (b)
            2'b00:   lvl = SYMBOL_N2;
            2'b01:   lvl = SYMBOL_N1;
            2'b11:   lvl = SYMBOL_P1;
            default: lvl = SYMBOL_P2;
        endcase
        return lvl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pam4_sym_src_if.sv
// ============================================================================
// Module      : pam4_sym_src_if
// Description : Symbol stream and strobe bundle from the PAM-4 source stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pam4_sym_src_if;
    import pam4_sym_src_pkg::*;

    logic                    sam_clk_en;
    logic                    sym_clk_en;
    logic signed [SYM_W-1:0] sym_out;
    logic                    seq_wrap;

    modport master (output sam_clk_en, output sym_clk_en, output sym_out, output seq_wrap);
    modport slave  (input  sam_clk_en, input  sym_clk_en, input  sym_out, input  seq_wrap);

endinterface

`default_nettype wire

// File: rtl/pam4_sym_src_prbs22_lfsr.sv
// ============================================================================
// Module      : prbs22_lfsr
// Description : x^22+x^21+1 Fibonacci LFSR, 0..2 shifts per clock, seed reload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs22_lfsr
    import pam4_sym_src_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 22'h3FFFFF
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              load_seed,
    input  wire logic [1:0]        step,
    output logic      [LFSR_W-1:0] state,
    output logic      [1:0]        dout
);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_base;
    logic [LFSR_W-1:0] w_s1;
    logic [LFSR_W-1:0] w_s2;
    logic [LFSR_W-1:0] w_next;

    // A seed load in the same cycle as a step shifts out of the seed itself
    always_comb begin
        w_base = load_seed ? SEED : r_state;
        w_s1   = {w_base[LFSR_W-2:0], w_base[LFSR_W-1] ^ w_base[LFSR_W-2]};
        w_s2   = {w_s1[LFSR_W-2:0],   w_s1[LFSR_W-1]   ^ w_s1[LFSR_W-2]};
        case (step)
            2'd0:    w_next = w_base;
            2'd1:    w_next = w_s1;
            default: w_next = w_s2;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= SEED;
        else          r_state <= w_next;
    end

    assign state = r_state;
    assign dout  = {w_base[LFSR_W-1], w_base[LFSR_W-2]};

endmodule

`default_nettype wire

// File: rtl/pam4_sym_src.sv
// ============================================================================
// Module      : pam4_sym_src
// Description : PAM-4 symbol source with sample/symbol enables (4 samples/sym).
//               Optional error injection: define PAM4_SRC_ERRINJ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pam4_sym_src
    import pam4_sym_src_pkg::*;
#(
    parameter int                CLK_PER_SAM = 4,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 22'h3FFFFF
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic       enable,
    input  wire logic [1:0] mode,
    input  wire logic       reseed,
    input  wire logic       err_inj,
    pam4_sym_src_if.master  src
);

    localparam int                  c_cnt_w   = (CLK_PER_SAM > 2) ? $clog2(CLK_PER_SAM) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_max = c_cnt_w'(CLK_PER_SAM - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_IMP_HOLD = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_cnt_w-1:0] r_clk_cnt;
    logic [1:0]         r_sam_cnt;
    logic [SYM_W-1:0]   r_sym;
    logic [SYM_W-1:0]   w_sym_new;
    logic               r_tone_ph;
    logic               r_prbs_loaded;
    logic               w_sam_en;
    logic               w_sym_en;
    logic               w_load;
    logic               w_prbs_load;
    logic               w_inj;
    logic [1:0]         w_prbs_bits;
    logic [LFSR_W-1:0]  w_lfsr_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Mode 1 leaving IDLE goes straight to IMP_HOLD: the impulse is loaded on that edge
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) w_next_state = (mode == MODE_IMP) ? S_IMP_HOLD : S_RUN;
            end
            S_RUN: begin
                if (!enable)                            w_next_state = S_IDLE;
                else if (w_sym_en && mode == MODE_IMP)  w_next_state = S_IMP_HOLD;
            end
            S_IMP_HOLD: begin
                if (!enable)                            w_next_state = S_IDLE;
                else if (w_sym_en && mode != MODE_IMP)  w_next_state = S_RUN;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_sam_en = (r_state != S_IDLE) && (r_clk_cnt == c_cnt_max);
        w_sym_en = w_sam_en && (r_sam_cnt == 2'd3);
    end

    assign w_load      = enable && ((r_state == S_IDLE) || w_sym_en);
    assign w_prbs_load = w_load && (mode == MODE_PRBS);

    prbs22_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_seed (reseed),
        .step      (w_prbs_load ? 2'd2 : 2'd0),
        .state     (w_lfsr_state),
        .dout      (w_prbs_bits)
    );

`ifdef PAM4_SRC_ERRINJ_EN
    logic r_err_arm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_err_arm <= 1'b0;
        else          r_err_arm <= (r_err_arm & ~w_prbs_load) | err_inj;
    end

    assign w_inj = r_err_arm;
`else
    logic w_unused_err_inj;
    assign w_unused_err_inj = err_inj;
    assign w_inj            = 1'b0;
`endif

    always_comb begin
        w_sym_new = '0;
        case (mode_e'(mode))
            MODE_PRBS: w_sym_new = gray_map(w_prbs_bits ^ {1'b0, w_inj});
            MODE_IMP:  w_sym_new = (r_state == S_IMP_HOLD) ? '0 : SYMBOL_P2;
            MODE_TONE: w_sym_new = r_tone_ph ? SYMBOL_N2 : SYMBOL_P2;
            default:   w_sym_new = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_cnt     <= '0;
            r_sam_cnt     <= '0;
            r_sym         <= '0;
            r_tone_ph     <= 1'b0;
            r_prbs_loaded <= 1'b0;
        end else begin
            r_prbs_loaded <= w_prbs_load;
            if ((r_state != S_IDLE) && enable) begin
                r_clk_cnt <= (r_clk_cnt == c_cnt_max) ? '0 : r_clk_cnt + 1'b1;
                if (w_sam_en) r_sam_cnt <= r_sam_cnt + 2'd1;
            end else begin
                r_clk_cnt <= '0;
                r_sam_cnt <= '0;
            end
            if (!enable)     r_sym <= '0;
            else if (w_load) r_sym <= w_sym_new;
            // Tone always restarts on P2 after any other mode or an idle spell
            if (w_load && mode == MODE_TONE)      r_tone_ph <= ~r_tone_ph;
            else if (w_load || r_state == S_IDLE) r_tone_ph <= 1'b0;
        end
    end

    assign src.sam_clk_en = w_sam_en;
    assign src.sym_clk_en = w_sym_en;
    assign src.sym_out    = r_sym;
    assign src.seq_wrap   = r_prbs_loaded && (w_lfsr_state == LFSR_SEED);

endmodule

`default_nettype wire

// File: tb/tb_pam4_sym_src.sv
// ============================================================================
// Module      : tb_pam4_sym_src
// Description : Scoreboard bench for pam4_sym_src (cycle model + expected queue).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pam4_sym_src;

    localparam int          CPS  = 4;
    localparam logic [21:0] SEED = 22'h3FFFFF;
    localparam logic [17:0] P2 = 18'h18000, P1 = 18'h08000, N1 = 18'h38000, N2 = 18'h28000;

    logic       clk = 1'b0;
    logic       reset_n, enable, reseed, err_inj;
    logic [1:0] mode;

    pam4_sym_src_if u_if ();

    pam4_sym_src #(.CLK_PER_SAM(CPS), .LFSR_SEED(SEED)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .mode    (mode),
        .reseed  (reseed),
        .err_inj (err_inj),
        .src     (u_if)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [17:0] q_exp[$];

    bit          m_run, m_imp_done, m_tone, m_arm, m_wrap, m_loaded;
    int          m_k;
    logic [21:0] m_lfsr;
    logic [17:0] m_hold;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [17:0] tb_gray(input logic [1:0] b);
        case (b)
            2'b00:   return N2;
            2'b01:   return N1;
            2'b11:   return P1;
            default: return P2;
        endcase
    endfunction

    function automatic logic [21:0] lfsr_step(input logic [21:0] s);
        return {s[20:0], s[21] ^ s[20]};
    endfunction

    task automatic model_reset();
        m_run = 0; m_k = 0; m_lfsr = SEED; m_imp_done = 0; m_tone = 0;
        m_arm = 0; m_wrap = 0; m_loaded = 0; m_hold = '0;
        q_exp.delete();
    endtask

    // Predicts the effect of the coming rising edge from the current inputs
    task automatic model_edge();
        logic [21:0] base;
        logic [1:0]  b;
        logic [17:0] s;
        bit          load, used;
        load = m_run ? (enable && (m_k % 16 == 15)) : enable;
        used = 0; m_wrap = 0; m_loaded = load; s = '0;
        if (load) begin
            case (mode)
                2'd0: begin
                    base = reseed ? SEED : m_lfsr;
                    b    = {base[21], base[20]};
`ifdef PAM4_SRC_ERRINJ_EN
                    if (m_arm) begin b[0] = ~b[0]; used = 1; end
`endif
                    s      = tb_gray(b);
                    m_lfsr = lfsr_step(lfsr_step(base));
                    m_wrap = (m_lfsr == SEED);
                end
                2'd1:    s = m_imp_done ? 18'h0 : P2;
                2'd2:    s = m_tone ? N2 : P2;
                default: s = '0;
            endcase
            m_imp_done = (mode == 2'd1);
            m_tone     = (mode == 2'd2) ? !m_tone : 1'b0;
            if (mode != 2'd0 && reseed) m_lfsr = SEED;
            q_exp.push_back(s);
            m_hold = s;
            if (!m_run) begin m_run = 1; m_k = 0; end
            else m_k++;
        end else begin
            if (reseed) m_lfsr = SEED;
            if (m_run && !enable) begin
                m_run = 0; m_k = 0; m_hold = '0; m_imp_done = 0; m_tone = 0;
            end else if (m_run) m_k++;
        end
`ifdef PAM4_SRC_ERRINJ_EN
        m_arm = (m_arm && !used) || err_inj;
`endif
    endtask

    task automatic cycle();
        logic [17:0] e;
        model_edge();
        @(negedge clk);
        check_val("sam_clk_en", 32'(u_if.sam_clk_en), 32'(m_run && (m_k % 4 == 3)));
        check_val("sym_clk_en", 32'(u_if.sym_clk_en), 32'(m_run && (m_k % 16 == 15)));
        check_val("seq_wrap",   32'(u_if.seq_wrap),   32'(m_wrap));
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            check_val("sym_load", {14'd0, u_if.sym_out}, {14'd0, e});
        end else begin
            check_val("sym_hold", {14'd0, u_if.sym_out}, {14'd0, m_hold});
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_syms(input int n);
        int got = 0;
        for (int c = 0; c < 20 * n && got < n; c++) begin
            cycle();
            if (m_loaded) got++;
        end
    endtask

    task automatic to_load_edge();
        for (int c = 0; c < 20 && !(m_run && (m_k % 16 == 15)); c++) cycle();
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; mode = 2'd0; reseed = 1'b0; err_inj = 1'b0;
        model_reset();
        run_cycles(3);
        reset_n = 1'b1;
        run_cycles(3);

        // PRBS start from default seed: P1 x11 then N2
        enable = 1'b1;
        cycle();
        check_val("prbs_first", {14'd0, u_if.sym_out}, {14'd0, P1});
        run_syms(10);
        check_val("prbs_sym11", {14'd0, u_if.sym_out}, {14'd0, P1});
        run_syms(1);
        check_val("prbs_sym12", {14'd0, u_if.sym_out}, {14'd0, N2});

        // Tone, changed mid-symbol
        run_cycles(5);
        mode = 2'd2;
        run_syms(1);
        check_val("tone_first", {14'd0, u_if.sym_out}, {14'd0, P2});
        run_syms(1);
        check_val("tone_second", {14'd0, u_if.sym_out}, {14'd0, N2});
        run_syms(4);

        // Impulse, then re-armed after a PRBS detour
        run_cycles(7);
        mode = 2'd1;
        run_syms(1);
        check_val("imp_pulse", {14'd0, u_if.sym_out}, {14'd0, P2});
        run_syms(1);
        check_val("imp_hold", 32'(u_if.sym_out), 32'd0);
        run_syms(2);
        run_cycles(3);
        mode = 2'd0;
        run_syms(2);
        run_cycles(2);
        mode = 2'd1;
        run_syms(1);
        check_val("imp_rearm", {14'd0, u_if.sym_out}, {14'd0, P2});
        run_syms(2);
        run_cycles(4);
        mode = 2'd3;
        run_syms(2);

        // Enable drop mid-symbol and resume
        mode = 2'd0;
        run_syms(3);
        run_cycles(6);
        enable = 1'b0;
        run_cycles(4);
        check_val("drop_sym", 32'(u_if.sym_out), 32'd0);
        enable = 1'b1;
        run_syms(5);

        // Reseed mid-symbol restarts the P1 x11 run
        run_cycles(3);
        reseed = 1'b1;
        cycle();
        reseed = 1'b0;
        run_syms(11);
        check_val("reseed_p1", {14'd0, u_if.sym_out}, {14'd0, P1});
        run_syms(1);
        check_val("reseed_n2", {14'd0, u_if.sym_out}, {14'd0, N2});

        // Reseed coincident with a load, then error injection on the next one
        to_load_edge();
        reseed = 1'b1;
        cycle();
        reseed = 1'b0;
        check_val("reseed_at_load", {14'd0, u_if.sym_out}, {14'd0, P1});
        run_cycles(2);
        err_inj = 1'b1;
        cycle();
        err_inj = 1'b0;
        run_syms(1);
`ifdef PAM4_SRC_ERRINJ_EN
        check_val("errinj_sym", {14'd0, u_if.sym_out}, {14'd0, P2});
`else
        check_val("errinj_sym", {14'd0, u_if.sym_out}, {14'd0, P1});
`endif
        run_syms(1);
        check_val("errinj_after", {14'd0, u_if.sym_out}, {14'd0, P1});

        // Long PRBS run against the model
        run_syms(300);

        // Asynchronous reset mid-symbol
        run_cycles(5);
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check_val("areset_sam", 32'(u_if.sam_clk_en), 32'd0);
        check_val("areset_sym_en", 32'(u_if.sym_clk_en), 32'd0);
        check_val("areset_sym", 32'(u_if.sym_out), 32'd0);
        check_val("areset_wrap", 32'(u_if.seq_wrap), 32'd0);
        model_reset();
        run_cycles(2);
        reset_n = 1'b1;
        enable  = 1'b1;
        mode    = 2'd0;
        cycle();
        check_val("post_reset_first", {14'd0, u_if.sym_out}, {14'd0, P1});
        run_syms(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
